// File: rtl/mfe_param.sv
// rtl/mfe_param.sv - 3x3 rank filter (median/min/max) over a raster image with zero or replicate padding
module mfe_param #(
    parameter int DW = 8,
    parameter int W_LOG2 = 7,
    parameter int H_LOG2 = 7,
    localparam int AW = W_LOG2 + H_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic [1:0]    mode,
    input  logic          pad_mode,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_wr,
    output logic          wen,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t        state, state_nx;
    logic [3:0]    tap;
    logic [AW-1:0] pix;
    logic [1:0]    mode_q;
    logic          pad_q;
    logic [DW-1:0] sbuf [9];
    logic [DW-1:0] ins [9];
    logic [DW-1:0] sample;
    logic [DW-1:0] result;

    // Tap k of pixel p, clamped into the image; k runs row-major over the 3x3 window.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] k);
        logic [W_LOG2-1:0] c;
        logic [H_LOG2-1:0] r;
        c = p[W_LOG2-1:0];
        r = p[AW-1:W_LOG2];
        if (k < 4'd3) begin
            if (r != '0) r = r - 1'b1;
        end else if (k >= 4'd6) begin
            if (r != '1) r = r + 1'b1;
        end
        if (k == 4'd0 || k == 4'd3 || k == 4'd6) begin
            if (c != '0) c = c - 1'b1;
        end else if (k == 4'd2 || k == 4'd5 || k == 4'd8) begin
            if (c != '1) c = c + 1'b1;
        end
        return {r, c};
    endfunction

    function automatic logic tap_oob(input logic [AW-1:0] p, input logic [3:0] k);
        logic [W_LOG2-1:0] c;
        logic [H_LOG2-1:0] r;
        logic o;
        c = p[W_LOG2-1:0];
        r = p[AW-1:W_LOG2];
        o = 1'b0;
        if (k < 4'd3 && r == '0) o = 1'b1;
        if (k >= 4'd6 && r == '1) o = 1'b1;
        if ((k == 4'd0 || k == 4'd3 || k == 4'd6) && c == '0) o = 1'b1;
        if ((k == 4'd2 || k == 4'd5 || k == 4'd8) && c == '1) o = 1'b1;
        return o;
    endfunction

    // The sample arriving now belongs to the tap addressed one cycle earlier.
    always_comb begin
        sample = idata;
        if (!pad_q && tap_oob(pix, tap - 4'd1)) sample = '0;
    end

    // Stable insertion: a new value goes after every entry less than or equal to it.
    always_comb begin
        ins[0] = (sbuf[0] <= sample) ? sbuf[0] : sample;
        for (int i = 1; i < 9; i++) begin
            if (sbuf[i] <= sample)        ins[i] = sbuf[i];
            else if (sbuf[i-1] <= sample) ins[i] = sample;
            else                          ins[i] = sbuf[i-1];
        end
    end

    always_comb begin
        case (mode_q)
            2'b01:   result = sbuf[0];
            2'b10:   result = sbuf[8];
            default: result = sbuf[4];
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ready) state_nx = LOAD;
            LOAD:    if (tap == 4'd9) state_nx = WRITE;
            WRITE:   state_nx = (pix == '1) ? DONE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tap     <= '0;
            pix     <= '0;
            mode_q  <= '0;
            pad_q   <= 1'b0;
            busy    <= 1'b0;
            wen     <= 1'b0;
            iaddr   <= '0;
            addr    <= '0;
            data_wr <= '0;
            for (int i = 0; i < 9; i++) sbuf[i] <= '1;
        end else begin
            state <= state_nx;
            wen   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        mode_q <= mode;
                        pad_q  <= pad_mode;
                        busy   <= 1'b1;
                        pix    <= '0;
                        tap    <= '0;
                        iaddr  <= tap_addr('0, 4'd0);
                        for (int i = 0; i < 9; i++) sbuf[i] <= '1;
                    end
                end
                LOAD: begin
                    if (tap != 4'd0) begin
                        for (int i = 0; i < 9; i++) sbuf[i] <= ins[i];
                    end
                    if (tap < 4'd8) iaddr <= tap_addr(pix, tap + 4'd1);
                    tap <= tap + 4'd1;
                end
                WRITE: begin
                    wen     <= 1'b1;
                    addr    <= pix;
                    data_wr <= result;
                    pix     <= pix + 1'b1;
                    tap     <= '0;
                    for (int i = 0; i < 9; i++) sbuf[i] <= '1;
                    if (pix != '1) iaddr <= tap_addr(pix + 1'b1, 4'd0);
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule
